alu_pipe: RTL and testbench

Parametrised, handshaked successor to the combinational 64-bit adder ALU. Performs ten arithmetic, logical, compare and shift operations on `WIDTH`-bit operands and registers the result behind a valid/ready interface. It sits between the decode/operand-fetch stage and writeback, so a stalled consumer back-pressures the issuing stage. Shifts are multi-cycle (serial) by default, or single-cycle when the barrel shifter is compiled in.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_shift_serial.sv | 49 ++++
 rtl/alu_pipe.sv | 106 ++++++++++
 tb/tb_alu_pipe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM state encodings and helpers for alu_pipe
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'd9;

    typedef enum logic {
        ALU_ST_IDLE  = 1'b0,
        ALU_ST_SHIFT = 1'b1
    } alu_state_t;

    function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_serial.sv
// rtl/alu_shift_serial.sv - one-bit-per-cycle shifter: work register, down counter, latched direction
module alu_shift_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    data,
    input  logic [SHW-1:0]      shamt,
    output logic                done,
    output logic [WIDTH-1:0]    result
);

    logic [WIDTH-1:0]    work;
    logic [SHW-1:0]      cnt;
    logic [ALU_OP_W-1:0] kind;

    // result is the work register after this cycle's one-bit step
    always_comb begin
        result = {1'b0, work[WIDTH-1:1]};
        case (kind)
            ALU_OP_SLL: result = {work[WIDTH-2:0], 1'b0};
            ALU_OP_SRA: result = {work[WIDTH-1], work[WIDTH-1:1]};
            default:    result = {1'b0, work[WIDTH-1:1]};
        endcase
    end

    assign done = (cnt == SHW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            work <= '0;
            cnt  <= '0;
            kind <= ALU_OP_SRL;
        end else if (start) begin
            work <= data;
            cnt  <= shamt;
            kind <= op;
        end else if (cnt != '0) begin
            work <= result;
            cnt  <= cnt - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked registered ALU; ALU_BARREL_SHIFT_EN selects single-cycle shifts
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [WIDTH-1:0]    inA_i,
    input  logic [WIDTH-1:0]    inB_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [WIDTH-1:0]    out_o,
    output logic                zero_o
);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] load_val;
    logic             accept;
    logic             load;

    assign shamt  = inB_i[SHW-1:0];
    assign accept = valid_i && ready_o;

    always_comb begin
        alu_res = '0;
        case (op_i)
            ALU_OP_ADD:  alu_res = inA_i + inB_i;
            ALU_OP_SUB:  alu_res = inA_i - inB_i;
            ALU_OP_AND:  alu_res = inA_i & inB_i;
            ALU_OP_OR:   alu_res = inA_i | inB_i;
            ALU_OP_XOR:  alu_res = inA_i ^ inB_i;
            ALU_OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(inA_i) < $signed(inB_i))};
            ALU_OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (inA_i < inB_i)};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_OP_SLL:  alu_res = inA_i << shamt;
            ALU_OP_SRL:  alu_res = inA_i >> shamt;
            ALU_OP_SRA:  alu_res = $unsigned($signed(inA_i) >>> shamt);
`else
            // only reaches the output when shamt is zero; otherwise the serial unit takes over
            ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA: alu_res = inA_i;
`endif
            default:     alu_res = '0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign ready_o  = !valid_o || ready_i;
    assign load     = accept;
    assign load_val = alu_res;
`else
    alu_state_t       state;
    logic             shift_start;
    logic             shift_done;
    logic [WIDTH-1:0] shift_result;

    assign ready_o     = (state == ALU_ST_IDLE) && (!valid_o || ready_i);
    assign shift_start = accept && is_shift_op(op_i) && (shamt != '0);
    assign load        = (accept && !shift_start) || ((state == ALU_ST_SHIFT) && shift_done);
    assign load_val    = (state == ALU_ST_SHIFT) ? shift_result : alu_res;

    alu_shift_serial #(.WIDTH(WIDTH)) u_shift (
        .clk    (clk_i),
        .reset  (reset_i),
        .start  (shift_start),
        .op     (op_i),
        .data   (inA_i),
        .shamt  (shamt),
        .done   (shift_done),
        .result (shift_result)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= ALU_ST_IDLE;
        end else begin
            case (state)
                ALU_ST_IDLE:  if (shift_start) state <= ALU_ST_SHIFT;
                ALU_ST_SHIFT: if (shift_done)  state <= ALU_ST_IDLE;
                default:      state <= ALU_ST_IDLE;
            endcase
        end
    end
`endif

    // a freshly loaded result wins over the drain of the previous one
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            out_o   <= '0;
            zero_o  <= 1'b1;
        end else if (load) begin
            valid_o <= 1'b1;
            out_o   <= load_val;
            zero_o  <= (load_val == '0);
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe (serial or ALU_BARREL_SHIFT_EN build)
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  op_i;
    logic [63:0] inA_i;
    logic [63:0] inB_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] out_o;
    logic        zero_o;

    int tests = 0;
    int fails = 0;

    alu_pipe #(.WIDTH(64)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .inA_i   (inA_i),
        .inB_i   (inB_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .out_o   (out_o),
        .zero_o  (zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
        int n;
        op_i = op; inA_i = a; inB_i = b; valid_i = 1'b1;
        check({tag, " ready"}, ready_o, 1);
        step();
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 80) begin
            step();
            n++;
        end
        check({tag, " valid"}, valid_o, 1);
        check({tag, " out"}, out_o, exp);
        check({tag, " zero"}, zero_o, (exp == 64'd0));
    endtask

    logic saw_valid;

    initial begin
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        op_i = 4'd0; inA_i = '0; inB_i = '0;
        step(); step();
        reset_i = 1'b0;
        step();
        check("rst ready", ready_o, 1);
        check("rst valid", valid_o, 0);
        check("rst out", out_o, 0);
        check("rst zero", zero_o, 1);

        // back-to-back ADD, SUB, SLTU
        valid_i = 1'b1; op_i = 4'd0; inA_i = 64'd3; inB_i = 64'd4;
        step();
        check("add valid", valid_o, 1);
        check("add out", out_o, 64'd7);
        check("b2b ready", ready_o, 1);
        op_i = 4'd1;
        step();
        check("sub out", out_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub zero", zero_o, 0);
        op_i = 4'd6; inA_i = 64'd1; inB_i = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check("sltu valid", valid_o, 1);
        check("sltu out", out_o, 64'd1);
        valid_i = 1'b0;
        step();
        check("drain valid", valid_o, 0);

        // SRA 0x8000... by 4
        valid_i = 1'b1; op_i = 4'd9; inA_i = 64'h8000_0000_0000_0000; inB_i = 64'd4;
        step();
        valid_i = 1'b0;
`ifdef ALU_BARREL_SHIFT_EN
        check("sra valid", valid_o, 1);
`else
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sra busy%0d ready", i), ready_o, 0);
            check($sformatf("sra busy%0d valid", i), valid_o, 0);
            step();
        end
        check("sra valid", valid_o, 1);
`endif
        check("sra out", out_o, 64'hF800_0000_0000_0000);
        check("sra ready", ready_o, 1);
        step();

        do_op("sll0", 4'd7, 64'h1234, 64'd0, 64'h1234);
        do_op("srl4", 4'd8, 64'h80F0, 64'd4, 64'h080F);
        do_op("sll63", 4'd7, 64'd1, 64'd63, 64'h8000_0000_0000_0000);
        do_op("sra_hi", 4'd9, 64'hF000_0000_0000_0000, 64'h44, 64'hFF00_0000_0000_0000);
        do_op("sra_pos", 4'd9, 64'h7000_0000_0000_0000, 64'd60, 64'd7);
        do_op("slt", 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        do_op("sltu_f", 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        do_op("or", 4'd3, 64'hF0, 64'h0F, 64'hFF);
        do_op("op12", 4'd12, 64'h55, 64'h66, 64'd0);
        do_op("and", 4'd2, 64'hF0, 64'h0F, 64'd0);
        step();

        // backpressure on XOR result
        ready_i = 1'b0;
        valid_i = 1'b1; op_i = 4'd4; inA_i = 64'hF0; inB_i = 64'hFF;
        step();
        op_i = 4'd0; inA_i = 64'd1; inB_i = 64'd1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp%0d out", i), out_o, 64'h0F);
            check($sformatf("bp%0d ready", i), ready_o, 0);
            check($sformatf("bp%0d valid", i), valid_o, 1);
            step();
        end
        ready_i = 1'b1;
        #1;
        check("bp release ready", ready_o, 1);
        step();
        check("bp next out", out_o, 64'd2);
        check("bp next valid", valid_o, 1);
        valid_i = 1'b0;
        step();
        check("bp drained", valid_o, 0);

        // reset on cycle 2 of SLL by 10
        saw_valid = 1'b0;
        valid_i = 1'b1; op_i = 4'd7; inA_i = 64'd1; inB_i = 64'd10;
        step();
        valid_i = 1'b0;
        saw_valid |= valid_o;
        step();
        saw_valid |= valid_o;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            saw_valid |= valid_o;
            step();
        end
`ifdef ALU_BARREL_SHIFT_EN
        check("abort saw valid", saw_valid, 1);
`else
        check("abort saw valid", saw_valid, 0);
`endif
        check("abort valid", valid_o, 0);
        check("abort ready", ready_o, 1);
        check("abort out", out_o, 0);
        check("abort zero", zero_o, 1);
        do_op("post abort add", 4'd0, 64'd5, 64'd6, 64'd11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
